// File: rtl/display_scheduler.sv
// display_scheduler
//   Chooses what the 4-digit 7-segment display shows each cycle: score,
//   level, the line-clear flash or the game-over message. Owns priority,
//   view rotation, blinking and leading-zero suppression. Timers only
//   advance on the display enable strobe.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   tick       one-cycle enable strobe, paces all timers
//   score_bcd  score, 4 BCD digits (thousands in [15:12])
//   level_bcd  level, 2 BCD digits (tens in [7:4])
//   aligne     one-cycle line-clear pulse
//   perdu      game lost (level)
//   digit3..0  digit codes to the Number driver, 15 = blank digit
//   blank      blanks the whole display
//   src        current view: 0 score, 1 level, 2 flash, 3 lost
//
// state     | meaning
// ROT_SCORE | rotation, showing score
// ROT_LEVEL | rotation, showing level
// FLASH     | line-clear flash, score view blinking
// LOST      | game over, message/score alternating (phase_q), blinking
module display_scheduler #(
    parameter int HOLD_TICKS  = 2000,
    parameter int BLINK_TICKS = 250,
    parameter int FLASH_TICKS = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] score_bcd,
    input  logic [7:0]  level_bcd,
    input  logic        aligne,
    input  logic        perdu,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic        blank,
    output logic [1:0]  src
);

    localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    // Timers are down-counters; the load value marks a freshly cleared timer.
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_TICKS - 1);

    // Encoding doubles as the src output.
    typedef enum logic [1:0] {
        ROT_SCORE = 2'd0,
        ROT_LEVEL = 2'd1,
        FLASH     = 2'd2,
        LOST      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;   // LOST only: 0 message, 1 score
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          blank_q, blank_d;
    logic [15:0]   digits_q, digits_d;

    logic          clr;
    logic          blink_en;
    logic [15:0]   score_view;
    logic [15:0]   level_view;

    logic [3:0] th, hu, te, un;
    assign th = score_bcd[15:12];
    assign hu = score_bcd[11:8];
    assign te = score_bcd[7:4];
    assign un = score_bcd[3:0];

    // Leading zeros blank out, units digit always shown.
    assign score_view = {
        (th == 4'd0) ? 4'hF : th,
        (th == 4'd0 && hu == 4'd0) ? 4'hF : hu,
        (th == 4'd0 && hu == 4'd0 && te == 4'd0) ? 4'hF : te,
        un
    };
    assign level_view = {8'hFF, (level_bcd[7:4] == 4'd0) ? 4'hF : level_bcd[7:4],
                         level_bcd[3:0]};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        blink_d  = blink_q;
        flash_d  = flash_q;
        blank_d  = blank_q;
        digits_d = digits_q;
        clr      = 1'b0;
        blink_en = 1'b0;

        case (state_q)
            ROT_SCORE, ROT_LEVEL: begin
                if (perdu) begin
                    state_d = LOST;
                    clr     = 1'b1;
                end else if (aligne) begin
                    state_d = FLASH;
                    clr     = 1'b1;
                end else if (tick) begin
                    if (hold_q == '0) begin
                        hold_d  = HOLD_LOAD;
                        state_d = (state_q == ROT_SCORE) ? ROT_LEVEL : ROT_SCORE;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            FLASH: begin
                if (perdu) begin
                    state_d = LOST;
                    clr     = 1'b1;
                end else if (aligne) begin
                    clr = 1'b1;    // restart, no queuing
                end else if (tick) begin
                    if (flash_q == '0) begin
                        state_d = ROT_SCORE;
                        clr     = 1'b1;
                    end else begin
                        flash_d  = flash_q - FW'(1);
                        blink_en = 1'b1;
                    end
                end
            end
            LOST: begin
                if (!perdu) begin
                    state_d = ROT_SCORE;
                    clr     = 1'b1;
                end else if (tick) begin
                    blink_en = 1'b1;
                    if (hold_q == '0) begin
                        hold_d  = HOLD_LOAD;
                        phase_d = ~phase_q;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            default: ;
        endcase

        if (blink_en) begin
            if (blink_q == '0) begin
                blink_d = BLINK_LOAD;
                blank_d = ~blank_q;
            end else begin
                blink_d = blink_q - BW'(1);
            end
        end

        // Any transition driven by perdu/aligne/flash end restarts every timer.
        if (clr) begin
            hold_d  = HOLD_LOAD;
            blink_d = BLINK_LOAD;
            flash_d = FLASH_LOAD;
            blank_d = 1'b0;
            phase_d = 1'b0;
        end

        if (state_d == ROT_LEVEL) begin
            digits_d = level_view;
        end else if (state_d == LOST && !phase_d) begin
            digits_d = 16'hDE1D;
        end else begin
            digits_d = score_view;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ROT_SCORE;
            phase_q  <= 1'b0;
            hold_q   <= HOLD_LOAD;
            blink_q  <= BLINK_LOAD;
            flash_q  <= FLASH_LOAD;
            blank_q  <= 1'b0;
            digits_q <= 16'hFFFF;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            blink_q  <= blink_d;
            flash_q  <= flash_d;
            blank_q  <= blank_d;
            digits_q <= digits_d;
        end
    end

    assign digit3 = digits_q[15:12];
    assign digit2 = digits_q[11:8];
    assign digit1 = digits_q[7:4];
    assign digit0 = digits_q[3:0];
    assign blank  = blank_q;
    assign src    = state_q;

endmodule
